cla_seq_adder: RTL and testbench
================================

# cla_seq_adder

Multi-cycle WIDTH-bit adder/subtractor that sequences a single 4-bit carry-lookahead slice over the operands, one nibble per clock, least-significant nibble first. The carry out of each slice pass (C4) is registered and fed back as the next pass's carry-in. The block sits in the ALU as the area-reduced add/sub path. It trades latency (WIDTH/4 cycles) for one shared lookahead group instead of a full multi-level CLA tree.

## Interface

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute a - b; captured on the accepting edge.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; holds until the next accepted start.
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow = C3 xor C4 of the final nibble pass.

## Operation

- States: IDLE, RUN, DONE. Nibble index k runs from 0 to N-1, where N = WIDTH/4.
- IDLE with start=1 at an edge:
  - Latch a into the A register.
  - Latch b, or ~b when sub=1, into the B register.
  - Carry register = (sub ? 1 : cin).
  - Clear k to 0, clear sum, cout and ovf to 0.
  - Go to RUN.
- IDLE with start=0: no state change.
- RUN, each edge, operating on nibble k:
  - gi = A[i] & B[i] and pi = A[i] ^ B[i], for i = 4k..4k+3.
  - Lookahead carries:
    - C1 = g0 | p0·c
    - C2 = g1 | p1·g0 | p1·p0·c
    - C3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·c
    - C4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·c
  - Nibble sum = p ^ {C3,C2,C1,c}. Write it to sum[4k+3:4k].
  - Carry register = C4.
  - k = k+1.
- Final RUN edge (k = N-1):
  - Also set cout = C4 and ovf = C3 ^ C4.
  - Go to DONE.
- DONE: done=1 for exactly this cycle. Next edge goes to IDLE unconditionally.
- start in RUN or DONE is ignored. It is neither queued nor allowed to change the operand registers. A new start is accepted only from IDLE.
- Changes on a, b, cin or sub after acceptance have no effect on the in-flight operation.
- Arithmetic is modulo 2^WIDTH.
  - Add: cout = unsigned carry out.
  - Sub: B is inverted with carry-in 1 (two's complement), so cout=0 indicates a borrow (a < b unsigned).
- rst (synchronous, at any state including mid-RUN) on the next edge:
  - State = IDLE, k = 0, carry register = 0.
  - sum = 0, cout = 0, ovf = 0, busy = 0, done = 0.
  - The in-flight operation is discarded and no done is generated.
  - rst has priority over start on the same edge.

## Timing

- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE.
- Start accepted at edge E0 (the block was in IDLE before E0):
  - busy rises after E0.
  - Nibble k is written at edge E(k+1).
  - done is high during the cycle after edge EN (N cycles after E0), and busy is low in that cycle.
- Back-to-back throughput: one operation per N+2 cycles. start held continuously high is accepted at E0, E(N+2), E(2N+4), and so on.
- During RUN, sum shows partially written results: low nibbles are final and high nibbles are 0. Consumers sample only on done.
- After done, sum, cout and ovf stay stable until the next accepting edge clears them.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

All scenarios use WIDTH=16, so N=4.

- Reset then idle: hold rst 2 cycles, then start=0 for 10 cycles → all outputs 0; busy and done never assert.
- Basic carry ripple: a=0x00FF, b=0x0001, cin=0, sub=0, start pulse at E0 → busy high 4 cycles; done high in the cycle after E4; sum=0x0100, cout=0, ovf=0.
- Carry-in and full wrap:
  - a=0x000F, b=0x0000, cin=1 → sum=0x0010.
  - a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0.
- Signed overflow and subtract:
  - a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0.
  - sub=1, a=0x0005, b=0x0007, cin=1 → sum=0xFFFE, cout=0, ovf=0 (cin ignored).
  - sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1, cout=1.
- Ignored start: start a=0x1234, b=0x1111; during RUN, pulse start with a=0xFFFF, b=0xFFFF → only one done is produced, sum=0x2345. Holding start high continuously → accepts spaced exactly 6 cycles apart.
- Reset mid-operation: accept a=0xFFFF, b=0x0001, assert rst at E2 → the next cycle shows busy=0, sum=0, cout=0, and no done follows. A subsequent start a=0x0001, b=0x0002 completes with sum=0x0003.

Source files
------------

// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
//   Area-reduced add/sub path for the ALU. A single 4-bit carry-lookahead
//   slice is reused over the operands, one nibble per clock, LS nibble first.
//   The slice carry-out is registered and becomes the next pass's carry-in.
//   Latency is WIDTH/4 cycles of RUN plus one DONE cycle.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (beats start)
//   start  in   request, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in for add, ignored for subtract
//   sub    in   1 = a - b
//   busy   out  high while nibbles are being processed
//   done   out  one-cycle pulse, result valid
//   sum    out  WIDTH-bit result, held until the next accepted start
//   cout   out  carry out of MSB (subtract: 1 = no borrow)
//   ovf    out  signed overflow (C3 ^ C4 of the last nibble pass)
// ---------------------------------------------------------------------------

// 4-bit lookahead group: flat two-level carries off generate/propagate.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] s,
    output logic       c3,
    output logic       c4
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c1 = g[0] | (p[0] & c);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c);
        s  = p ^ {c3, c2, c1, c};
    end
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [KW-1:0]    k_q;
    logic [3:0]       nib_s;
    logic             nib_c3;
    logic             nib_c4;
    logic             last;

    // Operand registers shift right by a nibble each pass, so the slice
    // always sees bits [3:0]; no wide operand mux is needed.
    cla4_slice u_slice (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .c  (c_q),
        .s  (nib_s),
        .c3 (nib_c3),
        .c4 (nib_c4)
    );

    assign last = (k_q == KW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded straight from the state register only.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            c_q  <= 1'b0;
            k_q  <= '0;
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q  <= a;
                        // Subtract as a + ~b + 1
                        b_q  <= sub ? ~b : b;
                        c_q  <= sub ? 1'b1 : cin;
                        k_q  <= '0;
                        sum  <= '0;
                        cout <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
                RUN: begin
                    sum[k_q*4 +: 4] <= nib_s;
                    a_q             <= a_q >> 4;
                    b_q             <= b_q >> 4;
                    c_q             <= nib_c4;
                    k_q             <= k_q + KW'(1);
                    if (last) begin
                        cout <= nib_c4;
                        ovf  <= nib_c3 ^ nib_c4;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_seq_adder
//   Scoreboard bench: each accepted request pushes the expected result and
//   the cycle its done pulse must appear in; a monitor pops and compares on
//   every done. Reference is plain wide arithmetic.
// ---------------------------------------------------------------------------
module tb_cla_seq_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc[$];

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    // Reference: wide addition of a and (possibly inverted) b.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms, input int ec);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] bb;
        bb     = ms ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (ms ? 1'b1 : mc)};
        e.s    = full[W-1:0];
        e.co   = full[W];
        e.ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        e.cyc  = ec;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done sum=%0h at cycle %0d", sum, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.co));
                chk("ovf", 32'(ovf), 32'(e.ov));
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ic, input logic is);
        int t = 0;
        while (busy !== 1'b0 || done !== 1'b0) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout busy=%b done=%b", busy, done);
                return;
            end
        end
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        q.push_back(model(ia, ib, ic, is, cyc + 1 + N));
        @(negedge clk);
        // Scramble inputs: in-flight operation must not see these.
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || busy !== 1'b0 || done !== 1'b0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d", q.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 10; i++) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
            @(negedge clk);
        end

        // Basic ripple with busy profile
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("done_after_EN", 32'(done), 32'd1);
        drain();

        // Directed corners
        issue(16'h000F, 16'h0000, 1'b1, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        drain();

        // start during RUN is ignored
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (8) @(negedge clk);

        // start held high: accepts every N+2 cycles
        a = 16'h0102; b = 16'h0304; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b0 && done === 1'b0) begin
                q.push_back(model(a, b, cin, sub, cyc + 1 + N));
                acc.push_back(cyc);
            end
            @(negedge clk);
        end
        start = 1'b0;
        drain();
        chk("held_accepts", 32'(acc.size()), 32'd4);
        for (int i = 0; i + 1 < acc.size(); i++)
            chk("accept_spacing", 32'(acc[i+1] - acc[i]), 32'(N + 2));

        // Reset mid-operation
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("mid_rst_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        issue(16'h0001, 16'h0002, 1'b0, 1'b0);
        drain();

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
